// File: rtl/sevseg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with a Wishbone slave.
// Blanking between digits avoids ghosting; all display outputs are registered.
module sevseg_scan_ctrl #(
  parameter logic [15:0] PRESCALE_RST = 16'd6250,
  parameter logic [7:0]  BLANK_CYCLES = 8'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [7:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_frame
);

  typedef enum logic {
    ST_BLANK   = 1'b0,
    ST_DISPLAY = 1'b1
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [31:0] r_digits;
  logic [7:0]  r_enable;
  logic [15:0] r_prescale;
  logic        r_ack;
  logic [31:0] r_dat;
  logic [7:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_frame;

  state_t      w_state_nxt;
  logic [15:0] w_cnt_nxt;
  logic [2:0]  w_idx_nxt;
  logic        w_frame_nxt;
  logic [7:0]  w_an_nxt;
  logic [6:0]  w_seg_nxt;
  logic [3:0]  w_nib;
  logic [15:0] w_ps_eff;
  logic        w_blank_done;
  logic        w_disp_done;
  logic        w_req;
  logic        w_wr;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_unused = ^wb_adr_i[1:0];

  function automatic logic [6:0] f_dec(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // A zero prescale would never satisfy the compare sensibly; run it as 1.
  assign w_ps_eff = (r_prescale == 16'd0) ? 16'd1 : r_prescale;
  assign w_blank_done = (BLANK_CYCLES == 8'd0) ||
                        (r_cnt >= ({8'd0, BLANK_CYCLES} - 16'd1));
  assign w_disp_done = (r_cnt >= (w_ps_eff - 16'd1));
  assign w_nib = r_digits[{w_idx_nxt, 2'b00} +: 4];

  // Next state, counter, index and the values the output registers take.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 16'd1;
    w_idx_nxt   = r_idx;
    w_frame_nxt = 1'b0;
    w_an_nxt    = 8'hFF;
    w_seg_nxt   = 7'h7F;
    unique case (r_state)
      ST_BLANK: begin
        if (w_blank_done) begin
          w_state_nxt = ST_DISPLAY;
          w_cnt_nxt   = 16'd0;
        end
      end
      ST_DISPLAY: begin
        if (w_disp_done) begin
          w_idx_nxt   = r_idx + 3'd1;
          w_cnt_nxt   = 16'd0;
          w_frame_nxt = (r_idx == 3'd7);
          w_state_nxt = (BLANK_CYCLES == 8'd0) ? ST_DISPLAY : ST_BLANK;
        end
      end
      default: ;
    endcase
    if (w_state_nxt == ST_DISPLAY) begin
      w_an_nxt  = ~({7'd0, r_enable[w_idx_nxt]} << w_idx_nxt);
      w_seg_nxt = f_dec(w_nib);
    end
  end

  // Scan state register and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BLANK;
      r_cnt   <= 16'd0;
      r_idx   <= 3'd0;
      r_an    <= 8'hFF;
      r_seg   <= 7'h7F;
      r_frame <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_an    <= w_an_nxt;
      r_seg   <= w_seg_nxt;
      r_frame <= w_frame_nxt;
    end
  end

  assign w_req = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr  = w_req & wb_we_i;

  // Register read mux; STATUS reports the live scan position.
  always_comb begin
    w_rdata = 32'd0;
    unique case (wb_adr_i[3:2])
      2'd0: w_rdata = r_digits;
      2'd1: w_rdata = {24'd0, r_enable};
      2'd2: w_rdata = {16'd0, r_prescale};
      2'd3: w_rdata = {28'd0, r_idx, r_state == ST_DISPLAY};
      default: ;
    endcase
  end

  // Single-cycle ack with byte-lane writes landing on the ack edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack      <= 1'b0;
      r_dat      <= 32'd0;
      r_digits   <= 32'd0;
      r_enable   <= 8'hFF;
      r_prescale <= PRESCALE_RST;
    end else begin
      r_ack <= w_req;
      r_dat <= w_req ? w_rdata : 32'd0;
      if (w_wr) begin
        unique case (wb_adr_i[3:2])
          2'd0: begin
            for (int b = 0; b < 4; b++)
              if (wb_sel_i[b])
                r_digits[8*b +: 8] <= wb_dat_i[8*b +: 8];
          end
          2'd1: begin
            if (wb_sel_i[0]) r_enable <= wb_dat_i[7:0];
          end
          2'd2: begin
            if (wb_sel_i[0]) r_prescale[7:0]  <= wb_dat_i[7:0];
            if (wb_sel_i[1]) r_prescale[15:8] <= wb_dat_i[15:8];
          end
          default: ;
        endcase
      end
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign o_an     = r_an;
  assign o_seg    = r_seg;
  assign o_frame  = r_frame;

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Directed bench for sevseg_scan_ctrl: register table, scan timing,
// enable masking, prescale changes, reset abort and ack pacing.
module tb_sevseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [7:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_frame;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  sevseg_scan_ctrl #(
    .PRESCALE_RST(16'd4),
    .BLANK_CYCLES(8'd2)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .o_an(o_an), .o_seg(o_seg), .o_frame(o_frame)
  );

  // Cycles since the last reset edge: the time base of the scan model.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct {
    logic [3:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] mask;
    logic [31:0] exp;
  } vec_t;

  vec_t tab [14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wb_req_ack(input logic [3:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic w,
                            output logic [31:0] rd);
    wb_adr_i = a; wb_dat_i = d; wb_sel_i = s; wb_we_i = w;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    step();
    chk("ack", {31'd0, wb_ack_o}, 32'd1);
    rd = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb(input logic [3:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic w,
                    output logic [31:0] rd);
    wb_req_ack(a, d, s, w, rd);
    step();
    chk("ack_low", {31'd0, wb_ack_o}, 32'd0);
  endtask

  task automatic scan_check(input int n, input logic [7:0] en,
                            input logic [31:0] dig);
    logic [7:0] ea;
    logic [6:0] es;
    logic ef;
    int d;
    for (int i = 0; i < n; i++) begin
      ea = 8'hFF; es = 7'h7F;
      if (cyc % 6 >= 2) begin
        d = (cyc / 6) % 8;
        ea = en[d] ? ~(8'd1 << d) : 8'hFF;
        es = seg_tab[dig[4*d +: 4]];
      end
      ef = (cyc > 0) && (cyc % 48 == 0);
      chk("scan", {16'd0, o_an, o_seg, o_frame}, {16'd0, ea, es, ef});
      step();
    end
  endtask

  task automatic wait_an(input logic want_blank);
    int k;
    k = 0;
    while (((o_an == 8'hFF) != want_blank) && k < 300) begin
      step();
      k++;
    end
    if (k >= 300) chk("wait_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int n;
    tab[0]  = '{4'h0, 32'hFFFF_FFFF, 4'b0010, 1'b1, 32'h0, 32'h0};
    tab[1]  = '{4'h0, 32'h0, 4'hF, 1'b0, 32'hFFFF_FFFF, 32'h0000_FF00};
    tab[2]  = '{4'h4, 32'hFFFF_FF05, 4'hF, 1'b1, 32'h0, 32'h0};
    tab[3]  = '{4'h4, 32'h0, 4'hF, 1'b0, 32'hFFFF_FFFF, 32'h0000_0005};
    tab[4]  = '{4'h8, 32'hABCD_0007, 4'b0001, 1'b1, 32'h0, 32'h0};
    tab[5]  = '{4'h8, 32'h0, 4'hF, 1'b0, 32'hFFFF_FFFF, 32'h0000_0007};
    tab[6]  = '{4'h8, 32'h1234_5600, 4'b0010, 1'b1, 32'h0, 32'h0};
    tab[7]  = '{4'h8, 32'h0, 4'hF, 1'b0, 32'hFFFF_FFFF, 32'h0000_5607};
    tab[8]  = '{4'hC, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0, 32'h0};
    tab[9]  = '{4'hC, 32'h0, 4'hF, 1'b0, 32'hFFFF_FFF0, 32'h0};
    tab[10] = '{4'h0, 32'h7654_3210, 4'hF, 1'b1, 32'h0, 32'h0};
    tab[11] = '{4'h0, 32'h0, 4'hF, 1'b0, 32'hFFFF_FFFF, 32'h7654_3210};
    tab[12] = '{4'h0, 32'h0000_00AA, 4'b0001, 1'b1, 32'h0, 32'h0};
    tab[13] = '{4'h0, 32'h0, 4'hF, 1'b0, 32'hFFFF_FFFF, 32'h7654_32AA};

    step();
    do_reset();
    chk("rst_an", {24'd0, o_an}, 32'hFF);
    chk("rst_seg", {25'd0, o_seg}, 32'h7F);
    chk("rst_frame", {31'd0, o_frame}, 32'd0);
    chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);

    for (int i = 0; i < 14; i++) begin
      wb(tab[i].adr, tab[i].dat, tab[i].sel, tab[i].we, rd);
      if (!tab[i].we)
        chk($sformatf("reg_rd%0d", i), rd & tab[i].mask, tab[i].exp);
    end

    do_reset();
    wb(4'h0, 32'h7654_3210, 4'hF, 1'b1, rd);
    scan_check(100, 8'hFF, 32'h7654_3210);

    wb(4'h4, 32'h0000_0005, 4'h1, 1'b1, rd);
    scan_check(60, 8'h05, 32'h7654_3210);

    n = 0;
    while (!((cyc % 6 == 2) && ((cyc / 6) % 8 == 5)) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("d5_timeout", 32'd0, 32'd1);
    chk("d5_an", {24'd0, o_an}, 32'hFF);
    do_reset();
    chk("mid_rst_an", {24'd0, o_an}, 32'hFF);
    wb(4'hC, 32'h0, 4'hF, 1'b0, rd);
    chk("mid_rst_status", rd, 32'd0);
    wb(4'h0, 32'h0, 4'hF, 1'b0, rd);
    chk("mid_rst_digits", rd, 32'd0);
    scan_check(50, 8'hFF, 32'd0);

    wb(4'h8, 32'd100, 4'b0011, 1'b1, rd);
    wait_an(1'b1);
    wait_an(1'b0);
    repeat (50) step();
    chk("ps100_lit", {31'd0, o_an != 8'hFF}, 32'd1);
    wb_req_ack(4'h8, 32'd10, 4'b0011, 1'b1, rd);
    chk("ps10_ack_lit", {31'd0, o_an != 8'hFF}, 32'd1);
    step();
    chk("ps10_end", {24'd0, o_an}, 32'hFF);

    wb(4'h8, 32'd0, 4'b0011, 1'b1, rd);
    wait_an(1'b1);
    wait_an(1'b0);
    n = 0;
    while (o_an != 8'hFF && n < 20) begin
      step();
      n++;
    end
    chk("ps0_lit_len", n, 32'd1);
    n = 0;
    while (o_an == 8'hFF && n < 20) begin
      step();
      n++;
    end
    chk("ps0_blank_len", n, 32'd2);

    wb_adr_i = 4'h4; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("b2b_ack%0d", i), {31'd0, wb_ack_o},
          (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
